// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU package: fetch FSM encodings, instruction field positions used by
// both the fetch stage and the controller decode path, and the default boot PC.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } fetchState_e;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned FUNC_MSB   = 27;
    localparam int unsigned FUNC_LSB   = 24;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0040;

endpackage

// File: rtl/instruction_fetch_unit_counter.sv
// event_counter: 32-bit event counter with synchronous active-high reset.
//   clk    - clock
//   reset  - synchronous clear
//   en     - count one event this cycle
//   count  - current count, wraps at 2^32
module event_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage. Holds the PC, drives word addresses to a
// synchronous instruction memory and presents instr/pc/pcPlus4 to decode with a
// valid/ready handshake. Execute may redirect with a one-cycle brTaken pulse.
//   clk, reset          - clock, synchronous active-high reset
//   imemAddr / imemData - memory word address out, data (one cycle later) in
//   ready               - decode accepts the presented instruction
//   brTaken / brTarget  - redirect request and byte target
//   instrValid, instr, opcode, func, pc, pcPlus4 - to decode
//   fetchState, fetchCount, stallCount, flushCount - debug
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 11,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_BITS-1:0] imemAddr,
    input  logic [31:0]          imemData,
    input  logic                 ready,
    input  logic                 brTaken,
    input  logic [31:0]          brTarget,
    output logic                 instrValid,
    output logic [31:0]          instr,
    output logic [3:0]           opcode,
    output logic [3:0]           func,
    output logic [31:0]          pc,
    output logic [31:0]          pcPlus4,
    output logic [1:0]           fetchState,
    output logic [31:0]          fetchCount,
    output logic [31:0]          stallCount,
    output logic [31:0]          flushCount
);

    logic [31:0] pcReg;
    logic [31:0] nextPc;
    logic        reqValid;
    logic        fire;
    fetchState_e state;
    fetchState_e stateNext;

    // A redirect squashes the word on imemData in the same cycle.
    assign instrValid = reqValid && !brTaken;
    assign fire       = instrValid && ready;

    // On a stall the same address is re-issued so the memory re-presents the
    // held word; no separate holding register is needed.
    always_comb begin
        nextPc = pcReg;
        if (brTaken) begin
            nextPc = brTarget & 32'hFFFF_FFFC;
        end else if (!reqValid) begin
            nextPc = pcReg;
        end else if (fire) begin
            nextPc = pcReg + 32'd4;
        end
    end

    assign imemAddr = nextPc[ADDR_BITS+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg    <= RESET_PC;
            reqValid <= 1'b0;
        end else begin
            pcReg    <= nextPc;
            reqValid <= 1'b1;
        end
    end

    assign instr   = imemData;
    assign opcode  = imemData[OPCODE_MSB:OPCODE_LSB];
    assign func    = imemData[FUNC_MSB:FUNC_LSB];
    assign pc      = pcReg;
    assign pcPlus4 = pcReg + 32'd4;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // FSM: next state
    always_comb begin
        stateNext = state;
        if (brTaken) begin
            stateNext = REDIRECT;
        end else if (state == BOOT) begin
            stateNext = RUN;
        end else if (reqValid && !ready) begin
            stateNext = STALL;
        end else begin
            stateNext = RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        fetchState = state;
    end

    event_counter uFetchCnt (
        .clk   (clk),
        .reset (reset),
        .en    (fire),
        .count (fetchCount)
    );

    event_counter uStallCnt (
        .clk   (clk),
        .reset (reset),
        .en    (instrValid && !ready),
        .count (stallCount)
    );

    event_counter uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .en    (brTaken),
        .count (flushCount)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [10:0] imemAddr;
    logic [31:0] imemData;
    logic        ready;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        instrValid;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  func;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [1:0]  fetchState;
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int unsigned total;
    int unsigned bad;

    logic [31:0] mem [2048];

    instruction_fetch_unit #(
        .ADDR_BITS (11),
        .RESET_PC  (32'h0000_0040)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .ready      (ready),
        .brTaken    (brTaken),
        .brTarget   (brTarget),
        .instrValid (instrValid),
        .instr      (instr),
        .opcode     (opcode),
        .func       (func),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .fetchState (fetchState),
        .fetchCount (fetchCount),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous instruction memory
    always @(posedge clk) imemData <= mem[imemAddr];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        expValid;
        logic [31:0] expPc;
        logic [10:0] expAddr;
        logic [1:0]  expState;
        logic [31:0] expFetch;
        logic [31:0] expStall;
        logic [31:0] expFlush;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] expQ[$];

    function automatic vec_t mk(logic rst, logic rdy, logic br, logic [31:0] tgt,
                                logic v, logic [31:0] p, logic [10:0] a, logic [1:0] s,
                                logic [31:0] fc, logic [31:0] sc, logic [31:0] flc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.expValid = v; r.expPc = p; r.expAddr = a; r.expState = s;
        r.expFetch = fc; r.expStall = sc; r.expFlush = flc;
        return r;
    endfunction

    function automatic logic [31:0] memWord(logic [31:0] byteAddr);
        logic [31:0] idx;
        idx = {21'd0, byteAddr[12:2]};
        return 32'hC000_0000 + idx;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkInstr(string tag, logic [31:0] p);
        logic [31:0] w;
        w = memWord(p);
        chk({tag, " instr"}, instr, w);
        chk({tag, " opcode"}, {28'd0, opcode}, {28'd0, w[31:28]});
        chk({tag, " func"}, {28'd0, func}, {28'd0, w[27:24]});
        chk({tag, " pcPlus4"}, pcPlus4, p + 32'd4);
    endtask

    initial begin
        string tag;
        int unsigned fires;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hC000_0000 + i;

        // row: rst rdy br tgt | valid pc addr state | fetch stall flush
        vecs.push_back(mk(0,1,0,32'h0,        0,32'h040,11'd16,  2'd0, 0,0,0));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h040,11'd17,  2'd1, 0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h044,11'd17,  2'd1, 1,0,0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h044,11'd17,  2'd2, 1,1,0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h044,11'd17,  2'd2, 1,2,0));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h044,11'd18,  2'd2, 1,3,0));
        vecs.push_back(mk(0,1,1,32'h103,      0,32'h048,11'd64,  2'd1, 2,3,0));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h100,11'd65,  2'd3, 2,3,1));
        vecs.push_back(mk(0,0,1,32'h180,      0,32'h104,11'd96,  2'd1, 3,3,1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h180,11'd97,  2'd3, 3,3,2));
        vecs.push_back(mk(0,1,1,32'hFFFFFFFC, 0,32'h184,11'd2047,2'd1, 4,3,2));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'hFFFFFFFC,11'd0,2'd3,4,3,3));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h000,11'd1,   2'd1, 5,3,3));
        vecs.push_back(mk(0,1,1,32'h200,      0,32'h004,11'd128, 2'd1, 6,3,3));
        vecs.push_back(mk(0,1,1,32'h300,      0,32'h200,11'd192, 2'd3, 6,3,4));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h300,11'd193, 2'd3, 6,3,5));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h304,11'd193, 2'd1, 7,3,5));
        vecs.push_back(mk(1,0,0,32'h0,        1,32'h304,11'd193, 2'd2, 7,4,5));
        vecs.push_back(mk(0,1,1,32'h200,      0,32'h040,11'd128, 2'd0, 0,0,0));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h200,11'd129, 2'd3, 0,0,1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h204,11'd130, 2'd1, 1,0,1));

        reset = 1'b1; ready = 1'b1; brTaken = 1'b0; brTarget = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset instrValid", {31'd0, instrValid}, 32'd0);
        chk("reset imemAddr", {21'd0, imemAddr}, 32'd16);
        chk("reset state", {30'd0, fetchState}, 32'd0);
        chk("reset fetchCount", fetchCount, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            ready    = vecs[i].rdy;
            brTaken  = vecs[i].br;
            brTarget = vecs[i].tgt;
            #1;
            tag = $sformatf("row%0d", i);
            chk({tag, " instrValid"}, {31'd0, instrValid}, {31'd0, vecs[i].expValid});
            chk({tag, " pc"}, pc, vecs[i].expPc);
            chk({tag, " imemAddr"}, {21'd0, imemAddr}, {21'd0, vecs[i].expAddr});
            chk({tag, " state"}, {30'd0, fetchState}, {30'd0, vecs[i].expState});
            chk({tag, " fetchCount"}, fetchCount, vecs[i].expFetch);
            chk({tag, " stallCount"}, stallCount, vecs[i].expStall);
            chk({tag, " flushCount"}, flushCount, vecs[i].expFlush);
            if (vecs[i].expValid) chkInstr(tag, vecs[i].expPc);
        end

        // Scoreboard phase: sequential stream under random back-pressure.
        @(negedge clk);
        reset = 1'b1; brTaken = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 12; k++) expQ.push_back(32'h40 + 32'(4 * k));
        fires = 0;
        for (int cyc = 0; cyc < 300 && expQ.size() > 0; cyc++) begin
            @(negedge clk);
            reset = 1'b0;
            ready = 1'($urandom_range(0, 1));
            #1;
            if (instrValid && ready) begin
                logic [31:0] e;
                e = expQ.pop_front();
                tag = $sformatf("sb%0d", fires);
                chk({tag, " pc"}, pc, e);
                chkInstr(tag, e);
                fires++;
            end
        end
        if (expQ.size() != 0) begin
            chk("sb timeout remaining", expQ.size(), 32'd0);
        end else begin
            @(negedge clk);
            ready = 1'b0;
            #1;
            chk("sb fetchCount", fetchCount, 32'd12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
